// File: rtl/data_mem_responder.sv
// Wait-stated word memory answering the control unit's MemEn/MemWen strobes.
// One request in flight; requests arriving while busy are dropped and flagged.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemEn,
    input  logic              MemWen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    localparam logic [3:0]    CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;
    logic [3:0]        next_cnt;
    logic              capture;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wen;
    logic              in_range;
    logic              do_write;
    logic              do_read;

    logic [DATA_W-1:0] mem [DEPTH];

    // Extra leading zero lets DEPTH == 2**ADDR_W compare without overflow.
    assign in_range = ({1'b0, req_addr} < DEPTH_LIM);
    assign do_write = (state == S_ACCESS) && req_wen && in_range;
    assign do_read  = (state == S_ACCESS) && !req_wen;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemEn) begin
                    capture = 1'b1;
                    if (WAIT_STATES > 0) begin
                        next_state = S_WAIT;
                        next_cnt   = CNT_INIT;
                    end else begin
                        next_state = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = S_ACCESS;
                end else begin
                    next_cnt = wait_cnt - 4'd1;
                end
            end
            S_ACCESS: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Request fields only move on capture, so strobes seen while busy cannot disturb them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_wen   <= 1'b0;
        end else if (capture) begin
            req_addr  <= addr;
            req_wdata <= wdata;
            req_wen   <= MemWen;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata     <= '0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mem_ready <= (state == S_ACCESS);
            mem_err   <= (state == S_ACCESS) && !in_range;
            if (do_read) begin
                rdata <= in_range ? mem[req_addr] : '0;
            end
            if (MemEn && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; an aborted access never reaches S_ACCESS.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[req_addr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a plain array model.
module tb_data_mem_responder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int WS     = 2;

    logic              clk     = 1'b0;
    logic              reset   = 1'b0;
    logic              MemEn   = 1'b0;
    logic              MemWen  = 1'b0;
    logic [ADDR_W-1:0] addr    = '0;
    logic [DATA_W-1:0] wdata   = '0;
    logic [DATA_W-1:0] rdata;
    logic              mem_ready;
    logic              mem_err;
    logic              busy;
    logic              overrun;

    int check_count = 0;
    int pass_count  = 0;

    logic [DATA_W-1:0] model_mem [1 << ADDR_W];
    logic [DATA_W-1:0] exp_rdata   = '0;
    logic              exp_overrun = 1'b0;

    data_mem_responder #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemEn    (MemEn),
        .MemWen   (MemWen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .mem_ready(mem_ready),
        .mem_err  (mem_err),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [ADDR_W-1:0] pickInRange();
        int idx;
        idx = $urandom_range(0, 19);
        if (idx <= 16) return ADDR_W'(idx);
        if (idx == 17) return ADDR_W'(32);
        if (idx == 18) return ADDR_W'(DEPTH - 2);
        return ADDR_W'(DEPTH - 1);
    endfunction

    // Issue one request at a falling edge; the request is sampled at the next rising edge (E0).
    // intrude: strobe again one cycle later while busy. chain: return in the mem_ready cycle.
    task automatic applyStimulus(input logic wen, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                 input bit intrude, input bit chain);
        int n;
        bit busy_ok;
        bit stray_ready;
        bit err_exp;
        MemEn  = 1'b1;
        MemWen = wen;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        MemEn  = 1'b0;
        MemWen = $urandom_range(0, 1);
        addr   = ADDR_W'($urandom);
        wdata  = $urandom;
        n       = 0;
        busy_ok = 1'b1;
        while (!mem_ready && n < 4 * WS + 8) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (intrude && n == 0) begin
                MemEn       = 1'b1;
                MemWen      = 1'b1;
                addr        = a ^ ADDR_W'(1);
                wdata       = ~d;
                exp_overrun = 1'b1;
            end else begin
                MemEn = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        MemEn = 1'b0;

        err_exp = ({22'd0, a} >= 32'(DEPTH));
        if (!err_exp && wen) model_mem[a] = d;
        if (!wen) exp_rdata = err_exp ? '0 : model_mem[a];

        checkOutput($sformatf("latency %s@%0h", wen ? "wr" : "rd", a), 32'(n), 32'(WS + 1));
        checkOutput($sformatf("busy_wait @%0h", a), 32'(busy_ok), 32'd1);
        checkOutput($sformatf("busy_at_ready @%0h", a), 32'(busy), 32'd0);
        checkOutput($sformatf("mem_ready @%0h", a), 32'(mem_ready), 32'd1);
        checkOutput($sformatf("mem_err @%0h", a), 32'(mem_err), 32'(err_exp));
        checkOutput($sformatf("rdata @%0h", a), rdata, exp_rdata);
        checkOutput($sformatf("overrun @%0h", a), 32'(overrun), 32'(exp_overrun));

        if (!chain) begin
            @(negedge clk);
            checkOutput("ready_one_cycle", 32'(mem_ready), 32'd0);
            checkOutput("err_one_cycle", 32'(mem_err), 32'd0);
            if (intrude) begin
                stray_ready = 1'b0;
                repeat (WS + 3) begin
                    @(negedge clk);
                    if (mem_ready !== 1'b0) stray_ready = 1'b1;
                end
                checkOutput("no_second_ready", 32'(stray_ready), 32'd0);
            end
        end
    endtask

    initial begin
        bit stray_ready;

        // Reset state while held low
        repeat (2) @(negedge clk);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_ready", 32'(mem_ready), 32'd0);
        checkOutput("reset_err", 32'(mem_err), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write leaves rdata alone, read returns the word
        applyStimulus(1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h005, 32'h0, 1'b0, 1'b0);

        // Populate the in-range address pool with known data
        for (int i = 0; i <= 16; i++) applyStimulus(1'b1, ADDR_W'(i), $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'd32, $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, ADDR_W'(DEPTH - 2), $urandom, 1'b0, 1'b0);
        applyStimulus(1'b1, ADDR_W'(DEPTH - 1), $urandom, 1'b0, 1'b0);

        // Range boundary
        applyStimulus(1'b0, ADDR_W'(DEPTH - 1), 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, ADDR_W'(DEPTH), 32'hA5A5A5A5, 1'b0, 1'b0);
        applyStimulus(1'b0, ADDR_W'(DEPTH), 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h000, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10'h3FF, 32'h5A5A5A5A, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h3FF, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'h000, 32'h0, 1'b0, 1'b0);

        // Requests issued in the mem_ready cycle
        applyStimulus(1'b1, 10'h003, 32'hCAFEF00D, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h003, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 10'h007, 32'h0, 1'b0, 1'b0);

        // Strobe while busy is dropped and flagged
        applyStimulus(1'b0, 10'h010, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 10'h011, 32'h0, 1'b0, 1'b0);

        // Reset during WAIT aborts a pending write
        MemEn  = 1'b1;
        MemWen = 1'b1;
        addr   = 10'h020;
        wdata  = 32'h12345678;
        @(negedge clk);
        MemEn = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rdata", rdata, 32'd0);
        checkOutput("abort_ready", 32'(mem_ready), 32'd0);
        checkOutput("abort_err", 32'(mem_err), 32'd0);
        checkOutput("abort_overrun", 32'(overrun), 32'd0);
        exp_rdata   = '0;
        exp_overrun = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stray_ready = 1'b0;
        repeat (WS + 3) begin
            @(negedge clk);
            if (mem_ready !== 1'b0) stray_ready = 1'b1;
        end
        checkOutput("abort_no_ready", 32'(stray_ready), 32'd0);
        applyStimulus(1'b0, 10'h020, 32'h0, 1'b0, 1'b0);

        // Random mix of reads, writes, out-of-range and back-to-back requests
        for (int i = 0; i < 60; i++) begin
            logic [ADDR_W-1:0] a;
            if ($urandom_range(0, 4) == 0) a = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
            else                           a = pickInRange();
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1'b0, ($urandom_range(0, 3) == 0));
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
